// File: rtl/memwb_stage_pkg.sv
// Shared constants for the MEM/WB stage and its users.
// MEMWB_SKID_EN is left undefined by default; define it to build the skid buffer.
package memwb_stage_pkg;

    localparam logic [4:0]  REG_NOP    = 5'd0;
    localparam logic [31:0] ZERO_WORD  = 32'h0;
    localparam logic [63:0] ZERO_DWORD = 64'h0;
    localparam int          BSEL_BUS_W = 4;

    typedef enum logic [7:0] {
        MT_NONE = 8'h00,
        MT_LB   = 8'h01,
        MT_LBU  = 8'h02,
        MT_LH   = 8'h03,
        MT_LHU  = 8'h04,
        MT_LW   = 8'h05,
        MT_SB   = 8'h11,
        MT_SH   = 8'h12,
        MT_SW   = 8'h13
    } mem_type_e;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/memwb_stage_if.sv
// MEM/WB beat bus: valid/ready handshake plus the per-lane and per-beat payload.
interface memwb_stage_if #(
    parameter int LANES = 2,
    parameter int DW    = 32,
    parameter int RAW   = 5,
    parameter int IAW   = 32
);
    import memwb_stage_pkg::*;

    logic                    valid;
    logic                    ready;
    logic [LANES-1:0]        lane_vld;
    logic [LANES-1:0]        wreg;
    logic [LANES-1:0]        mreg;
    logic [LANES*RAW-1:0]    wa;
    logic [LANES*DW-1:0]     wdata;
    logic [LANES*2-1:0]      whilo;
    logic [LANES*2*DW-1:0]   hilo;
    logic [LANES*8-1:0]      memtype;
    logic [LANES*IAW-1:0]    iaddr;
    logic [BSEL_BUS_W-1:0]   dre;
    logic                    wc0;
    logic [RAW-1:0]          cp0addr;
    logic [DW-1:0]           cp0wdata;
    logic [DW-1:0]           daddr;

    modport master (
        output valid, lane_vld, wreg, mreg, wa, wdata, whilo, hilo, memtype,
               iaddr, dre, wc0, cp0addr, cp0wdata, daddr,
        input  ready
    );

    modport slave (
        input  valid, lane_vld, wreg, mreg, wa, wdata, whilo, hilo, memtype,
               iaddr, dre, wc0, cp0addr, cp0wdata, daddr,
        output ready
    );

endinterface

// File: rtl/memwb_stage_waw_filter.sv
// Lane kill gating and same-beat write-after-write suppression (highest lane wins).
// Purely combinational; also used by the ID-stage issue checker.
module memwb_waw_filter #(
    parameter int LANES = 2,
    parameter int RAW   = 5
) (
    input  logic [LANES-1:0]     lane_vld_i,
    input  logic [LANES-1:0]     wreg_i,
    input  logic [LANES-1:0]     mreg_i,
    input  logic [LANES*RAW-1:0] wa_i,
    input  logic [LANES*2-1:0]   whilo_i,
    input  logic [LANES*8-1:0]   memtype_i,
    output logic [LANES-1:0]     wreg_o,
    output logic [LANES-1:0]     mreg_o,
    output logic [LANES*2-1:0]   whilo_o,
    output logic [LANES*8-1:0]   memtype_o
);

    logic [LANES-1:0]   wreg_g;
    logic [LANES*2-1:0] whilo_g;

    always_comb begin
        wreg_g    = wreg_i & lane_vld_i;
        mreg_o    = mreg_i & lane_vld_i;
        whilo_g   = '0;
        memtype_o = '0;
        for (int i = 0; i < LANES; i++) begin
            whilo_g[2*i +: 2] = whilo_i[2*i +: 2] & {2{lane_vld_i[i]}};
            if (lane_vld_i[i])
                memtype_o[8*i +: 8] = memtype_i[8*i +: 8];
        end

        // A lower lane loses its enable to any higher live lane hitting the same target.
        wreg_o  = wreg_g;
        whilo_o = whilo_g;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (wreg_g[i] && wreg_g[j] && (wa_i[RAW*i +: RAW] == wa_i[RAW*j +: RAW]))
                    wreg_o[i] = 1'b0;
                whilo_o[2*i +: 2] = whilo_o[2*i +: 2] & ~whilo_g[2*j +: 2];
            end
        end
    end

endmodule

// File: rtl/memwb_stage.sv
// MEM/WB pipeline register with valid/ready, lane kill and WAW suppression.
// Define MEMWB_SKID_EN to add a skid register so in_ready is fully registered.
module memwb_stage #(
    parameter int LANES = 2,
    parameter int DW    = 32,
    parameter int RAW   = 5,
    parameter int IAW   = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    memwb_stage_if.slave  mem_i,
    memwb_stage_if.master wb_o,
    output logic [2:0]    out_retire
);
    import memwb_stage_pkg::*;

    localparam int PW = LANES * (3 + RAW + DW + 2 + 2*DW + 8 + IAW)
                      + BSEL_BUS_W + 1 + RAW + 2*DW;

    logic [LANES-1:0]   wreg_f;
    logic [LANES-1:0]   mreg_f;
    logic [LANES*2-1:0] whilo_f;
    logic [LANES*8-1:0] memtype_f;
    logic [PW-1:0]      pay_in;

    logic [PW-1:0]      main_q, main_d;
    logic               main_vld_q, main_vld_d;
    logic               in_ready;
    logic               in_fire;
    logic               main_load;

    memwb_waw_filter #(.LANES(LANES), .RAW(RAW)) u_waw (
        .lane_vld_i (mem_i.lane_vld),
        .wreg_i     (mem_i.wreg),
        .mreg_i     (mem_i.mreg),
        .wa_i       (mem_i.wa),
        .whilo_i    (mem_i.whilo),
        .memtype_i  (mem_i.memtype),
        .wreg_o     (wreg_f),
        .mreg_o     (mreg_f),
        .whilo_o    (whilo_f),
        .memtype_o  (memtype_f)
    );

    assign pay_in = {mem_i.lane_vld, wreg_f, mreg_f, mem_i.wa, mem_i.wdata, whilo_f,
                     mem_i.hilo, memtype_f, mem_i.iaddr, mem_i.dre, mem_i.wc0,
                     mem_i.cp0addr, mem_i.cp0wdata, mem_i.daddr};

    assign main_load   = wb_o.ready || !main_vld_q;
    assign in_fire     = mem_i.valid && in_ready;
    assign mem_i.ready = in_ready;

`ifdef MEMWB_SKID_EN
    logic [PW-1:0] skid_q, skid_d;
    logic          skid_vld_q, skid_vld_d;

    // Only a full skid entry blocks the input, so in_ready never sees out_ready.
    assign in_ready = !skid_vld_q;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (main_load) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = in_fire;
                if (in_fire)
                    main_d = pay_in;
            end
        end else if (in_fire) begin
            skid_d     = pay_in;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn || flush) begin
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end
`else
    assign in_ready = main_load;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        if (main_load) begin
            main_vld_d = in_fire;
            if (in_fire)
                main_d = pay_in;
        end
    end
`endif

    // Clearing the payload too keeps every write enable low after reset or flush.
    always_ff @(posedge clk) begin
        if (resetn || flush) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
        end
    end

    assign wb_o.valid = main_vld_q;
    assign {wb_o.lane_vld, wb_o.wreg, wb_o.mreg, wb_o.wa, wb_o.wdata, wb_o.whilo,
            wb_o.hilo, wb_o.memtype, wb_o.iaddr, wb_o.dre, wb_o.wc0,
            wb_o.cp0addr, wb_o.cp0wdata, wb_o.daddr} = main_q;

    assign out_retire = main_vld_q ? popcount4(4'(main_q[PW-1 -: LANES])) : 3'd0;

endmodule

// File: tb/tb_memwb_stage.sv
// Self-checking bench for memwb_stage: directed cases plus random traffic against a queue model.
`timescale 1ns/1ps
module tb_memwb_stage;

    localparam int L   = 2;
    localparam int DW  = 32;
    localparam int RAW = 5;
    localparam int IAW = 32;

    typedef struct packed {
        logic [L-1:0]      lane_vld;
        logic [L-1:0]      wreg;
        logic [L-1:0]      mreg;
        logic [L*RAW-1:0]  wa;
        logic [L*DW-1:0]   wdata;
        logic [L*2-1:0]    whilo;
        logic [L*2*DW-1:0] hilo;
        logic [L*8-1:0]    memtype;
        logic [L*IAW-1:0]  iaddr;
        logic [3:0]        dre;
        logic              wc0;
        logic [RAW-1:0]    cp0addr;
        logic [DW-1:0]     cp0wdata;
        logic [DW-1:0]     daddr;
    } beat_t;

    logic       clk;
    logic       resetn;
    logic       flush;
    logic [2:0] out_retire;

    memwb_stage_if #(.LANES(L), .DW(DW), .RAW(RAW), .IAW(IAW)) up ();
    memwb_stage_if #(.LANES(L), .DW(DW), .RAW(RAW), .IAW(IAW)) dn ();

    memwb_stage #(.LANES(L), .DW(DW), .RAW(RAW), .IAW(IAW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .mem_i      (up),
        .wb_o       (dn),
        .out_retire (out_retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t q[$];
    int    n_checks;
    int    n_errors;
    bit    chk_en;
    bit    clr_all;
    bit    clr_en;
    bit    last_fire;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input beat_t b);
        up.lane_vld = b.lane_vld;  up.wreg     = b.wreg;     up.mreg    = b.mreg;
        up.wa       = b.wa;        up.wdata    = b.wdata;    up.whilo   = b.whilo;
        up.hilo     = b.hilo;      up.memtype  = b.memtype;  up.iaddr   = b.iaddr;
        up.dre      = b.dre;       up.wc0      = b.wc0;      up.cp0addr = b.cp0addr;
        up.cp0wdata = b.cp0wdata;  up.daddr    = b.daddr;
    endtask

    function automatic beat_t cur_in();
        beat_t r;
        r.lane_vld = up.lane_vld;  r.wreg     = up.wreg;     r.mreg    = up.mreg;
        r.wa       = up.wa;        r.wdata    = up.wdata;    r.whilo   = up.whilo;
        r.hilo     = up.hilo;      r.memtype  = up.memtype;  r.iaddr   = up.iaddr;
        r.dre      = up.dre;       r.wc0      = up.wc0;      r.cp0addr = up.cp0addr;
        r.cp0wdata = up.cp0wdata;  r.daddr    = up.daddr;
        return r;
    endfunction

    function automatic beat_t dut_beat();
        beat_t r;
        r.lane_vld = dn.lane_vld;  r.wreg     = dn.wreg;     r.mreg    = dn.mreg;
        r.wa       = dn.wa;        r.wdata    = dn.wdata;    r.whilo   = dn.whilo;
        r.hilo     = dn.hilo;      r.memtype  = dn.memtype;  r.iaddr   = dn.iaddr;
        r.dre      = dn.dre;       r.wc0      = dn.wc0;      r.cp0addr = dn.cp0addr;
        r.cp0wdata = dn.cp0wdata;  r.daddr    = dn.daddr;
        return r;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        b.lane_vld = 2'($urandom_range(0, 3));
        b.wreg     = 2'($urandom_range(0, 3));
        b.mreg     = 2'($urandom_range(0, 3));
        for (int i = 0; i < L; i++)
            b.wa[RAW*i +: RAW] = 5'($urandom_range(0, 3));
        b.wdata    = {$urandom, $urandom};
        b.whilo    = 4'($urandom_range(0, 15));
        b.hilo     = {$urandom, $urandom, $urandom, $urandom};
        b.memtype  = 16'($urandom);
        b.iaddr    = {$urandom, $urandom};
        b.dre      = 4'($urandom_range(0, 15));
        b.wc0      = 1'($urandom_range(0, 1));
        b.cp0addr  = 5'($urandom_range(0, 31));
        b.cp0wdata = $urandom;
        b.daddr    = $urandom;
        return b;
    endfunction

    // Walk lanes from the top down: the first live lane to claim a register or HI/LO bit keeps it.
    function automatic beat_t filt(input beat_t b);
        beat_t       r;
        logic [31:0] claimed;
        logic [1:0]  hl_claimed;
        r          = b;
        claimed    = '0;
        hl_claimed = '0;
        for (int j = L - 1; j >= 0; j--) begin
            if (!b.lane_vld[j]) begin
                r.wreg[j]          = 1'b0;
                r.mreg[j]          = 1'b0;
                r.whilo[2*j +: 2]  = 2'b00;
                r.memtype[8*j +: 8] = 8'h00;
            end else begin
                if (b.wreg[j]) begin
                    if (claimed[b.wa[RAW*j +: RAW]]) r.wreg[j] = 1'b0;
                    else claimed[b.wa[RAW*j +: RAW]] = 1'b1;
                end
                for (int k = 0; k < 2; k++) begin
                    if (b.whilo[2*j + k]) begin
                        if (hl_claimed[k]) r.whilo[2*j + k] = 1'b0;
                        else hl_claimed[k] = 1'b1;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic model_ready();
`ifdef MEMWB_SKID_EN
        return q.size() < 2;
`else
        return dn.ready || (q.size() == 0);
`endif
    endfunction

    task automatic compare();
        if (!chk_en) return;
        chk("out_valid", dn.valid, q.size() != 0);
        chk("in_ready", up.ready, model_ready());
        chk("out_retire", out_retire, (q.size() != 0) ? $countones(q[0].lane_vld) : 0);
        if (q.size() != 0)
            chk("payload", dut_beat(), q[0]);
        if (clr_all)
            chk("reset_zero", {dut_beat(), out_retire, dn.valid}, '0);
        if (clr_en)
            chk("flush_enables", {dn.wreg, dn.mreg, dn.whilo, dn.memtype, dn.wc0}, '0);
    endtask

    task automatic model_update();
        logic rdy;
        rdy       = model_ready();
        clr_all   = 1'b0;
        clr_en    = 1'b0;
        last_fire = 1'b0;
        if (resetn) begin
            q.delete();
            clr_all = 1'b1;
        end else if (flush) begin
            q.delete();
            clr_en = 1'b1;
        end else begin
            if (q.size() != 0 && dn.ready) void'(q.pop_front());
            if (up.valid && rdy) begin
                q.push_back(filt(cur_in()));
                last_fire = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        model_update();
        @(posedge clk);
        #1;
    endtask

    beat_t b;
    beat_t h;

    initial begin
        n_checks = 0; n_errors = 0; chk_en = 0; clr_all = 0; clr_en = 0; last_fire = 0;
        resetn = 1'b1; flush = 1'b0;
        b = '0;
        drive(b);
        up.valid = 1'b0; dn.ready = 1'b0;
        #1;
        step();
        chk_en = 1;
        step();
        resetn = 1'b0;
        step();
        chk("rst_out_valid", dn.valid, 1'b0);
        chk("rst_in_ready", up.ready, 1'b1);
        chk("rst_retire", out_retire, 3'd0);

        // Two lanes writing r5: only lane1 keeps its enable.
        b = '0; b.lane_vld = 2'b11; b.wreg = 2'b11; b.wa = {5'd5, 5'd5};
        b.wdata = {32'h22, 32'h11};
        drive(b); up.valid = 1'b1; dn.ready = 1'b1;
        step();
        chk("waw_wreg", dn.wreg, 2'b10);
        chk("waw_retire", out_retire, 3'd2);
        chk("waw_wdata", dn.wdata, 64'h00000022_00000011);

        // Killed lane1 loses all enables.
        b = '0; b.lane_vld = 2'b01; b.wreg = 2'b11; b.whilo = 4'b1100;
        b.wa = {5'd7, 5'd3}; b.memtype = {8'h21, 8'h00};
        drive(b);
        step();
        chk("kill_wreg", dn.wreg, 2'b01);
        chk("kill_whilo", dn.whilo, 4'b0000);
        chk("kill_memtype", dn.memtype, 16'h0000);
        chk("kill_retire", out_retire, 3'd1);

        // HI/LO per-bit suppression: lane0 keeps HI, lane1 takes LO.
        b = '0; b.lane_vld = 2'b11; b.whilo = 4'b0111;
        drive(b);
        step();
        chk("hilo_whilo", dn.whilo, 4'b0110);

        up.valid = 1'b0; dn.ready = 1'b0;
        #1;
`ifdef MEMWB_SKID_EN
        chk("ready_skid_empty", up.ready, 1'b1);
`else
        chk("ready_follow_low", up.ready, 1'b0);
        dn.ready = 1'b1;
        #1;
        chk("ready_follow_high", up.ready, 1'b1);
        dn.ready = 1'b0;
`endif
        step();

        // Stream A, B, C with a two-cycle stall starting once B is presented.
        dn.ready = 1'b1; up.valid = 1'b1;
        drive(rnd_beat()); step();
        drive(rnd_beat()); step();
        dn.ready = 1'b0;
        drive(rnd_beat());
        for (int k = 0; k < 10; k++) begin
            if (k == 2) dn.ready = 1'b1;
            step();
            if (last_fire) break;
        end
        chk("stream_c_accepted", last_fire, 1'b1);
        up.valid = 1'b0;
        repeat (3) step();

        // Fill the stage while stalled, then flush with a beat on the input.
        dn.ready = 1'b0; up.valid = 1'b1;
        b = rnd_beat(); b.lane_vld = 2'b11; b.wreg = 2'b11; b.whilo = 4'b1111;
        drive(b); step();
        b = rnd_beat(); b.lane_vld = 2'b11; b.wreg = 2'b11;
        drive(b); step(); step();
        b = rnd_beat(); b.lane_vld = 2'b11; b.wreg = 2'b11;
        drive(b); flush = 1'b1;
        step();
        flush = 1'b0; up.valid = 1'b0;
        chk("flush_valid", dn.valid, 1'b0);
        chk("flush_wreg", dn.wreg, 2'b00);
        chk("flush_whilo", dn.whilo, 4'b0000);
        chk("flush_in_ready", up.ready, 1'b1);
        dn.ready = 1'b1;
        repeat (3) step();

        // Reset together with flush mid-stream, then one beat after release.
        up.valid = 1'b1; drive(rnd_beat()); step();
        resetn = 1'b1; flush = 1'b1; drive(rnd_beat());
        step();
        chk("midrst_zero", {dut_beat(), out_retire, dn.valid}, '0);
        resetn = 1'b0; flush = 1'b0;
        h = rnd_beat();
        drive(h);
        step();
        up.valid = 1'b0;
        chk("midrst_first_valid", dn.valid, 1'b1);
        chk("midrst_first_wdata", dn.wdata, h.wdata);
        step();

        for (int c = 0; c < 3000; c++) begin
            up.valid = ($urandom_range(0, 9) < 7);
            dn.ready = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 99) < 3);
            resetn   = ($urandom_range(0, 199) == 0);
            drive(rnd_beat());
            step();
        end
        resetn = 1'b0; flush = 1'b0; up.valid = 1'b0; dn.ready = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memwb_stage.md
# memwb_stage

Parametrised MEM/WB pipeline stage for the multi-issue core, sitting between the memory stage and register-file/HI-LO/CP0 writeback. It carries LANES instruction slots per beat and adds three things to the basic MEM/WB register:
- a valid/ready handshake, so downstream can stall;
- per-lane kill;
- same-beat write-after-write suppression, so writeback never sees two lanes writing one destination.

An optional skid buffer keeps `in_ready` fully registered.

## Interface
Parameters:
- LANES, 2, instruction slots per beat (1..4)
- DW, 32, register data width
- RAW, 5, register address width
- IAW, 32, instruction address width

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-high reset (sampled on posedge clk; asserted = 1)
- flush  in  1  exception/ERET flush; discards all held and incoming beats
- in_valid  in  1  beat offered by MEM
- in_ready  out  1  stage can accept a beat
- in_lane_vld  in  LANES  per-lane live bit; 0 = lane killed
- in_wreg, in_mreg  in  LANES  GPR write enable; load-result select
- in_wa  in  LANES*RAW  GPR destination
- in_wdata  in  LANES*DW  GPR write data
- in_whilo  in  LANES*2  HI/LO write enables {hi,lo}
- in_hilo  in  LANES*2*DW  HI/LO data
- in_memtype  in  LANES*8  memory op type
- in_iaddr  in  LANES*IAW  instruction PC
- in_dre  in  4  load byte enables
- in_wc0  in  1  CP0 write enable
- in_cp0addr  in  RAW  CP0 register address
- in_cp0wdata  in  DW  CP0 write data
- in_daddr  in  DW  data address
- out_valid  out  1  beat presented to WB
- out_ready  in  1  WB accepts beat
- out_* for every in_* payload field, same widths; out_lane_vld  out  LANES
- out_retire  out  3  count of live lanes in presented beat (0 when !out_valid)

## Operation
- A transfer occurs on a cycle with in_valid && in_ready. A beat leaves on a cycle with out_valid && out_ready.
- Input gating, combinational, applied before capture. For each lane with in_lane_vld = 0:
  - wreg, mreg, whilo and memtype are forced to 0;
  - data fields pass through unchanged.
- WAW suppression, applied after gating:
  - For lanes i < j, if both gated wreg = 1 and wa equal, lane i's wreg is cleared.
  - whilo bits are suppressed the same way, per bit.
  - Highest lane wins.
  - A write to register 0 is still passed; the regfile ignores it.
- Killed lanes still occupy their slot. out_lane_vld reflects the captured in_lane_vld.
- out_retire = popcount(out_lane_vld) when out_valid, else 0.
- Storage is a main register (output) plus, with the skid option, one skid register.
- Precedence: resetn > flush > normal.
- flush: main and skid valid are cleared next edge. A beat offered in the flush cycle is discarded. All write-enable outputs read 0 the following cycle.
- Reset values: every output is 0, except in_ready = 1 in the first cycle after reset deasserts.

## Timing
- Latency is 1 cycle, in → out, when not stalled. Back-to-back throughput is 1 beat/cycle.
- Main register loads when out_ready || !out_valid. Otherwise it holds; payload is stable while out_valid && !out_ready.
- With skid: in_ready = !skid_valid, registered.
  - If a beat is accepted while main is held, it goes to skid. in_ready drops the next cycle.
  - When out_ready returns: skid → main, and in_ready rises the next cycle.
  - Skid full and main full is the only state with in_ready = 0.
- Without skid: in_ready = out_ready || !out_valid, combinational.
- flush during a stall clears both entries. in_ready = 1 the next cycle.

## Configuration
- MEMWB_SKID_EN defined: skid register present; in_ready has no combinational path from out_ready.
- MEMWB_SKID_EN undefined: skid logic is removed; in_ready is the combinational expression above. Latency and throughput are unchanged.

## Structure
- Shared package/defines (defines.v): REG_NOP, ZERO_WORD, ZERO_DWORD, BSEL_BUS widths, the memtype encoding, and the MEMWB_SKID_EN default.
- Sub-module memwb_waw_filter: purely combinational lane gating and WAW suppression, parametrised by LANES/RAW. It is reused by the ID-stage issue checker.

## Test plan
- LANES=2. Lane0 wa=5 wdata=0x11, lane1 wa=5 wdata=0x22, both wreg=1 → next cycle out_wreg=2'b10, out_retire=2.
- in_lane_vld=2'b01, lane1 wreg=1 whilo=2'b11 → out_wreg[1]=0, out_whilo lane1=0, out_retire=1.
- Stream beats A,B,C with out_ready low for 2 cycles from B (skid on) → in_ready low 1 cycle. Output order is A,B,C with no loss or duplication; out_* stable while stalled.
- flush while main and skid are full and in_valid=1 → next cycle out_valid=0, all enables 0, in_ready=1. The offered beat never appears.
- resetn=1 mid-stream with flush=1 → all outputs 0 next cycle. First beat after release arrives 1 cycle after acceptance.
- MEMWB_SKID_EN undefined: out_valid=1 with out_ready toggled → in_ready equals out_ready in the same cycle.
